// File: rtl/alu.sv
// 8-bit registered ALU with NZCV flags for the CPU datapath; one-cycle latency.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] OP_Code,
  output logic [7:0] Result,
  output logic [3:0] NZCV
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ASR = 3'b111
  } op_e;

  op_e        op;
  logic [8:0] wide;
  logic [7:0] res;
  logic       carry;
  logic       ovf;
  logic [3:0] flags;

  assign op = op_e'(OP_Code);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    wide  = 9'd0;
    res   = 8'h00;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, A} + {1'b0, B};
        res   = wide[7:0];
        carry = wide[8];
        ovf   = (A[7] == B[7]) && (wide[7] != A[7]);
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the borrow: set iff A < B unsigned.
        wide  = {1'b0, A} - {1'b0, B};
        res   = wide[7:0];
        carry = wide[8];
        ovf   = (A[7] != B[7]) && (wide[7] != A[7]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_SHL: begin
        res   = {A[6:0], 1'b0};
        carry = A[7];
      end
      OP_SHR: begin
        res   = {1'b0, A[7:1]};
        carry = A[0];
      end
      OP_ASR: begin
        res   = {A[7], A[7:1]};
        carry = A[0];
      end
      default: res = 8'h00;
    endcase
`ifdef ALU_SAT_EN
    // On overflow the true result has the sign of A, so clamp toward it.
    if (ovf) res = A[7] ? 8'h80 : 8'h7F;
`else
`endif
  end

  assign flags = {res[7], (res == 8'h00), carry, ovf};

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      Result <= 8'h00;
      NZCV   <= 4'b0000;
    end else if (en) begin
      Result <= res;
      NZCV   <= flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expectations follow ALU_SAT_EN when it is defined.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OP_Code;
  logic [7:0] Result;
  logic [3:0] NZCV;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, ASR = 3'b111;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .A      (A),
    .B      (B),
    .OP_Code(OP_Code),
    .Result (Result),
    .NZCV   (NZCV)
  );

  always #5 clk = ~clk;

  // Apply inputs at the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst = r; en = e; OP_Code = op; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_res, input logic [3:0] exp_nzcv);
    compared++;
    assert (Result === exp_res) else begin
      mismatched++;
      $error("FAIL %s Result: observed %h expected %h", tag, Result, exp_res);
    end
    compared++;
    assert (NZCV === exp_nzcv) else begin
      mismatched++;
      $error("FAIL %s NZCV: observed %b expected %b", tag, NZCV, exp_nzcv);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; OP_Code = ADD; A = 8'h00; B = 8'h00;

    step(1'b1, 1'b0, ADD, 8'h00, 8'h00); check("reset",        8'h00, 4'b0000);
    step(1'b0, 1'b1, ADD, 8'h00, 8'h00); check("add_zero",     8'h00, 4'b0100);
    step(1'b0, 1'b1, ADD, 8'hE4, 8'hA2); check("add_carry",    8'h86, 4'b1010);
    step(1'b0, 1'b1, ADD, 8'h0A, 8'hE4); check("add_nocarry",  8'hEE, 4'b1000);
    step(1'b0, 1'b1, SUB, 8'hFF, 8'h00); check("sub_ff_00",    8'hFF, 4'b1000);
`ifdef ALU_SAT_EN
    step(1'b0, 1'b1, SUB, 8'h6C, 8'hBA); check("sub_ovf",      8'h7F, 4'b0011);
    step(1'b0, 1'b1, ADD, 8'h7F, 8'h01); check("add_pos_ovf",  8'h7F, 4'b0001);
    step(1'b0, 1'b1, ADD, 8'h80, 8'hFF); check("add_neg_ovf",  8'h80, 4'b1011);
`else
    step(1'b0, 1'b1, SUB, 8'h6C, 8'hBA); check("sub_ovf",      8'hB2, 4'b1011);
    step(1'b0, 1'b1, ADD, 8'h7F, 8'h01); check("add_pos_ovf",  8'h80, 4'b1001);
    step(1'b0, 1'b1, ADD, 8'h80, 8'hFF); check("add_neg_ovf",  8'h7F, 4'b0011);
`endif
    step(1'b0, 1'b1, SUB, 8'h37, 8'h37); check("sub_equal",    8'h00, 4'b0100);
    step(1'b0, 1'b1, AND_, 8'hE6, 8'h2C); check("and",         8'h24, 4'b0000);
    step(1'b0, 1'b1, OR_,  8'hBC, 8'h12); check("or",          8'hBE, 4'b1000);
    step(1'b0, 1'b1, XOR_, 8'h14, 8'hBA); check("xor",         8'hAE, 4'b1000);
    step(1'b0, 1'b1, SHL, 8'h84, 8'hFF); check("shl",          8'h08, 4'b0010);
    step(1'b0, 1'b1, SHR, 8'h5D, 8'hFF); check("shr_c1",       8'h2E, 4'b0010);
    step(1'b0, 1'b1, SHR, 8'h5C, 8'h00); check("shr_c0",       8'h2E, 4'b0000);
    step(1'b0, 1'b1, ASR, 8'h84, 8'h00); check("asr",          8'hC2, 4'b1000);
    step(1'b0, 1'b0, ADD, 8'h0A, 8'hE4); check("hold_en0",     8'hC2, 4'b1000);
    step(1'b0, 1'b0, SUB, 8'h00, 8'h01); check("hold_en0_b",   8'hC2, 4'b1000);
    step(1'b1, 1'b1, ADD, 8'hE4, 8'hA2); check("rst_over_en",  8'h00, 4'b0000);
    step(1'b0, 1'b1, SHL, 8'h40, 8'h00); check("after_reset",  8'h80, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
